// File: rtl/obi_bridge_pkg.sv
// Shared types for the OBI-to-peripheral bridge: FSM state encoding,
// the default error read pattern and the latched request record.
package obi_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

endpackage

// File: rtl/obi_periph_bridge_if.sv
// Bus bundle for the bridge: the OBI request/grant/rvalid channel plus the
// ready-handshaked peripheral register bus. slave = bridge side, master = environment side.
interface obi_periph_bridge_if;

    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;

    logic        pbus_req_o;
    logic [31:0] pbus_addr_o;
    logic        pbus_we_o;
    logic [3:0]  pbus_be_o;
    logic [31:0] pbus_wdata_o;
    logic        pbus_ready_i;
    logic [31:0] pbus_rdata_i;

    modport slave (
        input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        input  pbus_ready_i, pbus_rdata_i,
        output obi_gnt_o, obi_rvalid_o, obi_rdata_o,
        output pbus_req_o, pbus_addr_o, pbus_we_o, pbus_be_o, pbus_wdata_o
    );

    modport master (
        output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        output pbus_ready_i, pbus_rdata_i,
        input  obi_gnt_o, obi_rvalid_o, obi_rdata_o,
        input  pbus_req_o, pbus_addr_o, pbus_we_o, pbus_be_o, pbus_wdata_o
    );

endinterface

// File: rtl/obi_bridge_wdt.sv
// Peripheral access watchdog: counts ACCESS cycles without ready and flags
// expiry during the TIMEOUT_CYCLES-th such cycle.
module obi_bridge_wdt #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic active_i,
    input  logic ready_i,
    output logic expire_o
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;

    // cnt_q holds the number of waited cycles already completed, so the
    // current cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
    assign expire_o = active_i && !ready_i && (cnt_q == LAST_COUNT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= '0;
        end else if (active_i && !ready_i && !expire_o) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/obi_periph_bridge.sv
// OBI subordinate that turns each granted transaction into one peripheral bus
// access. Optional access watchdog: define OBI_BRIDGE_TIMEOUT_EN.
module obi_periph_bridge
    import obi_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter logic [31:0] END_ADDR       = 32'h1000_1FFF,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    obi_periph_bridge_if.slave  bus,
    output logic                bad_access_o
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("obi_periph_bridge: TIMEOUT_CYCLES must be 1..65535");
    end

    state_e      state_q, state_d;
    obi_req_t    req_q;
    logic [31:0] rdata_q;
    logic        bad_q;
    logic        in_range;
    logic        handshake;
    logic        wdt_expire;

    assign in_range  = (bus.obi_addr_i >= BASE_ADDR) && (bus.obi_addr_i <= END_ADDR);
    assign handshake = bus.obi_req_i && (state_q != ACCESS);

`ifdef OBI_BRIDGE_TIMEOUT_EN
    obi_bridge_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (handshake && in_range),
        .active_i (state_q == ACCESS),
        .ready_i  (bus.pbus_ready_i),
        .expire_o (wdt_expire)
    );
`else
    assign wdt_expire = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (bus.obi_req_i) begin
                    state_d = in_range ? ACCESS : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (bus.pbus_ready_i || wdt_expire) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is gated by rst_ni so it drops the instant reset is asserted.
    always_comb begin
        bus.obi_gnt_o    = 1'b0;
        bus.obi_rvalid_o = 1'b0;
        bus.pbus_req_o   = 1'b0;
        bus.pbus_addr_o  = '0;
        bus.pbus_we_o    = 1'b0;
        bus.pbus_be_o    = '0;
        bus.pbus_wdata_o = '0;
        unique case (state_q)
            IDLE: begin
                bus.obi_gnt_o = bus.obi_req_i && rst_ni;
            end
            RESP: begin
                bus.obi_gnt_o    = bus.obi_req_i && rst_ni;
                bus.obi_rvalid_o = 1'b1;
            end
            ACCESS: begin
                bus.pbus_req_o   = 1'b1;
                bus.pbus_addr_o  = req_q.addr - BASE_ADDR;
                bus.pbus_we_o    = req_q.we;
                bus.pbus_be_o    = req_q.be;
                bus.pbus_wdata_o = req_q.wdata;
            end
            default: ;
        endcase
    end

    // NOTE: the request latch is reset along with the control state; it is a
    // handful of flops, and a defined value keeps pbus_* deterministic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= '0;
            rdata_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            bad_q <= 1'b0;
            if (handshake) begin
                req_q <= '{addr:  bus.obi_addr_i,
                           we:    bus.obi_we_i,
                           be:    bus.obi_be_i,
                           wdata: bus.obi_wdata_i};
                if (!in_range) begin
                    rdata_q <= bus.obi_we_i ? '0 : ERR_RDATA;
                    bad_q   <= 1'b1;
                end
            end else if (state_q == ACCESS) begin
                // Ready takes priority over a coincident watchdog expiry.
                if (bus.pbus_ready_i) begin
                    rdata_q <= req_q.we ? '0 : bus.pbus_rdata_i;
                end else if (wdt_expire) begin
                    rdata_q <= req_q.we ? '0 : ERR_RDATA;
                    bad_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.obi_rdata_o = rdata_q;
    assign bad_access_o    = bad_q;

endmodule

// File: tb/tb_obi_periph_bridge.sv
// Self-checking bench for obi_periph_bridge: directed cases plus randomized
// transactions checked cycle by cycle against a transaction-level model.
module tb_obi_periph_bridge;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] END_A = 32'h1000_1FFF;
    localparam logic [31:0] ERR   = 32'hDEAD_BEEF;
    localparam int          TMO   = 16;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          gap;
        int          waits;
    } txn_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic bad_access_o;

    obi_periph_bridge_if bus ();

    obi_periph_bridge #(
        .BASE_ADDR      (BASE),
        .END_ADDR       (END_A),
        .ERR_RDATA      (ERR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .bus          (bus),
        .bad_access_o (bad_access_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    txn_t        txn_q[$];
    txn_t        cur;
    txn_t        acc;
    bit          req_active = 1'b0;
    bit          acc_active = 1'b0;
    int          acc_cnt    = 0;
    int          acc_wait   = 0;
    int          rv_due     = -1;
    logic [31:0] rv_data    = '0;
    logic        rv_bad     = 1'b0;
    logic [31:0] last_rdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [3:0] b,
                                input logic [31:0] wd, input logic [31:0] pr,
                                input int gap, input int waits);
        txn_t t;
        t.addr = a; t.we = w; t.be = b; t.wdata = wd; t.prdata = pr;
        t.gap = gap; t.waits = waits;
        return t;
    endfunction

    function automatic bit legal(input logic [31:0] a);
        return (a >= BASE) && (a <= END_A);
    endfunction

    task automatic schedule_resp(input logic [31:0] data, input logic bad);
        rv_due  = cyc + 1;
        rv_data = data;
        rv_bad  = bad;
    endtask

    // One clock: drive at posedge+1, sample at posedge+3, then advance the model.
    task automatic tick();
        logic exp_gnt;
        txn_t t;
        @(posedge clk_i);
        #1;
        cyc++;
        if (!req_active && txn_q.size() != 0) begin
            t = txn_q.pop_front();
            if (t.gap > 0) begin
                t.gap--;
                txn_q.push_front(t);
            end else begin
                cur = t;
                req_active = 1'b1;
            end
        end
        if (req_active) begin
            bus.obi_req_i   = 1'b1;
            bus.obi_addr_i  = cur.addr;
            bus.obi_we_i    = cur.we;
            bus.obi_be_i    = cur.be;
            bus.obi_wdata_i = cur.wdata;
        end else begin
            bus.obi_req_i   = 1'b0;
            bus.obi_addr_i  = $urandom;
            bus.obi_we_i    = 1'($urandom_range(0, 1));
            bus.obi_be_i    = 4'($urandom);
            bus.obi_wdata_i = $urandom;
        end
        bus.pbus_rdata_i = acc_active ? acc.prdata : $urandom;
        bus.pbus_ready_i = acc_active ? (acc_wait == 0) : 1'($urandom_range(0, 1));
        #2;

        exp_gnt = req_active && !acc_active;
        check("gnt", 32'(bus.obi_gnt_o), 32'(exp_gnt));
        check("pbus_req", 32'(bus.pbus_req_o), 32'(acc_active));
        if (acc_active) begin
            check("pbus_addr", bus.pbus_addr_o, acc.addr - BASE);
            check("pbus_we", 32'(bus.pbus_we_o), 32'(acc.we));
            check("pbus_be", 32'(bus.pbus_be_o), 32'(acc.be));
            check("pbus_wdata", bus.pbus_wdata_o, acc.wdata);
        end
        if (rv_due == cyc) begin
            check("rvalid", 32'(bus.obi_rvalid_o), 32'd1);
            check("rdata", bus.obi_rdata_o, rv_data);
            check("bad_access", 32'(bad_access_o), 32'(rv_bad));
            last_rdata = rv_data;
        end else begin
            check("rvalid_idle", 32'(bus.obi_rvalid_o), 32'd0);
            check("bad_access_idle", 32'(bad_access_o), 32'd0);
            check("rdata_hold", bus.obi_rdata_o, last_rdata);
        end

        if (acc_active) begin
            if (bus.pbus_ready_i) begin
                schedule_resp(acc.we ? 32'd0 : acc.prdata, 1'b0);
                acc_active = 1'b0;
            end else begin
                acc_cnt++;
                acc_wait--;
`ifdef OBI_BRIDGE_TIMEOUT_EN
                if (acc_cnt == TMO) begin
                    schedule_resp(acc.we ? 32'd0 : ERR, 1'b1);
                    acc_active = 1'b0;
                end
`endif
            end
        end
        if (exp_gnt) begin
            req_active = 1'b0;
            if (legal(cur.addr)) begin
                acc        = cur;
                acc_active = 1'b1;
                acc_cnt    = 0;
                acc_wait   = cur.waits;
            end else begin
                schedule_resp(cur.we ? 32'd0 : ERR, 1'b1);
            end
        end
    endtask

    task automatic run_all(input int limit);
        int n = 0;
        while ((txn_q.size() != 0 || req_active || acc_active || rv_due > cyc) && n < limit) begin
            tick();
            n++;
        end
        check("drain_in_budget", 32'(n < limit), 32'd1);
    endtask

    task automatic reset_mid_access();
        int n = 0;
        txn_q.push_back(mk(BASE + 32'h40, 1'b0, 4'hF, 32'h0, $urandom, 0, 1000));
        while (!acc_active && n < 50) begin
            tick();
            n++;
        end
        check("rst_mid_reached", 32'(acc_active), 32'd1);
        @(posedge clk_i);
        #3;
        check("pre_rst_pbus_req", 32'(bus.pbus_req_o), 32'd1);
        bus.obi_req_i = 1'b1;
        rst_ni = 1'b0;
        #1;
        check("rst_pbus_req", 32'(bus.pbus_req_o), 32'd0);
        check("rst_rvalid", 32'(bus.obi_rvalid_o), 32'd0);
        check("rst_gnt", 32'(bus.obi_gnt_o), 32'd0);
        check("rst_rdata", bus.obi_rdata_o, 32'd0);
        acc_active = 1'b0;
        req_active = 1'b0;
        rv_due     = -1;
        last_rdata = '0;
        bus.obi_req_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #4;
        check("rst_hold_rvalid", 32'(bus.obi_rvalid_o), 32'd0);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        bus.obi_req_i    = 1'b1;
        bus.obi_addr_i   = BASE;
        bus.obi_we_i     = 1'b0;
        bus.obi_be_i     = 4'hF;
        bus.obi_wdata_i  = $urandom;
        bus.pbus_ready_i = 1'b1;
        bus.pbus_rdata_i = $urandom;
        #12;
        check("reset_gnt", 32'(bus.obi_gnt_o), 32'd0);
        check("reset_rvalid", 32'(bus.obi_rvalid_o), 32'd0);
        check("reset_rdata", bus.obi_rdata_o, 32'd0);
        check("reset_pbus_req", 32'(bus.pbus_req_o), 32'd0);
        check("reset_pbus_addr", bus.pbus_addr_o, 32'd0);
        check("reset_pbus_we", 32'(bus.pbus_we_o), 32'd0);
        check("reset_pbus_be", 32'(bus.pbus_be_o), 32'd0);
        check("reset_pbus_wdata", bus.pbus_wdata_o, 32'd0);
        check("reset_bad", 32'(bad_access_o), 32'd0);
        bus.obi_req_i = 1'b0;
        #6;
        rst_ni = 1'b1;

        // Zero-wait read, 3-wait write, out-of-range read.
        txn_q.push_back(mk(32'h1000_0010, 1'b0, 4'hF, 32'h0, 32'hA5A5_0001, 1, 0));
        txn_q.push_back(mk(32'h1000_0004, 1'b1, 4'b0011, 32'h1234_5678, 32'hFFFF_FFFF, 2, 3));
        txn_q.push_back(mk(32'h8000_0000, 1'b0, 4'hF, 32'h0, 32'h0, 2, 0));
        // Four back-to-back zero-wait reads with continuous request.
        for (int i = 0; i < 4; i++) begin
            txn_q.push_back(mk(BASE + 32'(i * 4), 1'b0, 4'hF, 32'h0, 32'hC0DE_0000 + 32'(i), (i == 0) ? 2 : 0, 0));
        end
        run_all(200);

        reset_mid_access();
        txn_q.push_back(mk(32'h1000_0100, 1'b0, 4'hF, 32'h0, 32'h5EED_0001, 0, 1));
        run_all(100);

`ifdef OBI_BRIDGE_TIMEOUT_EN
        txn_q.push_back(mk(32'h1000_0200, 1'b0, 4'hF, 32'h0, 32'h0, 1, 1000));
        txn_q.push_back(mk(32'h1000_0204, 1'b1, 4'hF, 32'hAAAA_5555, 32'h0, 1, 1000));
        txn_q.push_back(mk(32'h1000_0208, 1'b0, 4'hF, 32'h0, 32'h7777_1234, 1, TMO - 1));
        run_all(400);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0:       a = BASE;
                1:       a = END_A;
                2:       a = BASE - 32'd1;
                3:       a = END_A + 32'd1;
                4:       a = BASE + 32'($urandom_range(0, 32'h1FFF));
                default: a = $urandom;
            endcase
            txn_q.push_back(mk(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
                               int'($urandom_range(0, 2)), int'($urandom_range(0, 3))));
        end
        run_all(5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
